// File: rtl/mux8_rr_scheduler.sv
// -----------------------------------------------------------------------------
// mux8_rr_scheduler
//   Round-robin scheduler in front of an 8:1 data multiplexer. It shares one
//   output channel between eight requesters. Each cycle it picks one requester
//   using a rotating priority pointer, and registers that requester's word into
//   a single-entry valid/ready output stage.
//
// Ports
//   clk        in   1     system clock, rising edge
//   rst        in   1     asynchronous reset, active-high
//   req        in   8     req[i]=1: requester i presents a word
//   in_data    in   8*DW  word i at in_data[i*DW +: DW]
//   gnt        out  8     one-hot accept pulse; word i is taken at this edge
//   out_valid  out  1     out_data/out_sel hold a word
//   out_ready  in   1     consumer accepts the word when out_valid & out_ready
//   out_data   out  DW    registered selected word
//   out_sel    out  3     index of the requester that supplied out_data
// -----------------------------------------------------------------------------
module mux8_rr_scheduler #(
    parameter int DW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [7:0]      req,
    input  logic [8*DW-1:0] in_data,
    output logic [7:0]      gnt,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   out_data,
    output logic [2:0]      out_sel
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [2:0] ptr;
    logic       slot_free;
    logic       win_found;
    logic [2:0] win_idx;
    logic [2:0] scan_idx;
    logic       grant;

    assign out_valid = (state == FULL);

    // The output slot can take a new word when it is empty, or when its
    // current word leaves at this same edge (back-to-back handoff).
    assign slot_free = ~out_valid | out_ready;

    // Scan ptr, ptr+1, ..., ptr+7. The 3-bit add wraps modulo 8.
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr;
        scan_idx  = ptr;
        for (int i = 0; i < 8; i++) begin
            scan_idx = ptr + 3'(i);
            if (!win_found && req[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    // gnt is forced low while rst is asserted, even though rst is asynchronous
    // to the combinational grant path.
    always_comb begin
        gnt = '0;
        if (!rst && slot_free && win_found) begin
            gnt[win_idx] = 1'b1;
        end
    end

    assign grant = |gnt;

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: begin
                if (grant) begin
                    state_nxt = FULL;
                end
            end
            FULL: begin
                if (out_ready && !grant) begin
                    state_nxt = EMPTY;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    // The output stage registers update only on a grant. On a stall or an idle
    // cycle, out_data and out_sel hold their values. The pointer also holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= EMPTY;
            ptr      <= 3'd0;
            out_data <= '0;
            out_sel  <= 3'd0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                out_data <= in_data[win_idx*DW +: DW];
                out_sel  <= win_idx;
                ptr      <= win_idx + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_mux8_rr_scheduler.sv
module tb_mux8_rr_scheduler;

    localparam int DW = 8;

    logic            clk;
    logic            rst;
    logic [7:0]      req;
    logic [8*DW-1:0] in_data;
    logic [7:0]      gnt;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   out_data;
    logic [2:0]      out_sel;

    int n_cmp;
    int n_err;

    mux8_rr_scheduler #(.DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .in_data   (in_data),
        .gnt       (gnt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] exp_gnt;
        n_cmp     = 0;
        n_err     = 0;
        rst       = 1'b1;
        req       = 8'hFF;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) in_data[i*DW +: DW] = 8'(8'h10 + i);

        // Test 1: reset state
        tick();
        tick();
        chk("rst_gnt", 32'(gnt), 32'h00);
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_sel", 32'(out_sel), 32'h0);
        chk("rst_data", 32'(out_data), 32'h00);
        rst = 1'b0;
        #1;
        chk("first_gnt", 32'(gnt), 32'h01);

        // Test 2: full rotation 0..7,0
        for (int i = 0; i < 9; i++) begin
            exp_gnt = 8'h01 << (i % 8);
            chk("rot_gnt", 32'(gnt), 32'(exp_gnt));
            tick();
            chk("rot_valid", 32'(out_valid), 32'h1);
            chk("rot_sel", 32'(out_sel), 32'(i % 8));
            chk("rot_data", 32'(out_data), 32'(8'h10 + (i % 8)));
        end

        // Move the pointer to 6 by granting requester 5 alone.
        req = 8'h20;
        #1;
        chk("pre6_gnt", 32'(gnt), 32'h20);
        tick();
        chk("pre6_sel", 32'(out_sel), 32'h5);

        // Test 3: wrap and skip with ptr=6. Grants alternate between 6 and 0.
        req = 8'b0100_0001;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("wrap_gnt", 32'(gnt), (i % 2 == 0) ? 32'h40 : 32'h01);
            tick();
            chk("wrap_sel", 32'(out_sel), (i % 2 == 0) ? 32'h6 : 32'h0);
        end

        // Test 4: stall while holding requester 3's word 8'hA5. The pointer is now 1.
        in_data[3*DW +: DW] = 8'hA5;
        req = 8'h08;
        #1;
        chk("st_gnt3", 32'(gnt), 32'h08);
        tick();
        chk("st_sel3", 32'(out_sel), 32'h3);
        chk("st_data3", 32'(out_data), 32'hA5);
        out_ready = 1'b0;
        req = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_gnt", 32'(gnt), 32'h00);
            tick();
            chk("stall_valid", 32'(out_valid), 32'h1);
            chk("stall_data", 32'(out_data), 32'hA5);
            chk("stall_sel", 32'(out_sel), 32'h3);
        end
        out_ready = 1'b1;
        #1;
        chk("unstall_gnt", 32'(gnt), 32'h10);
        tick();
        chk("unstall_sel", 32'(out_sel), 32'h4);
        chk("unstall_data", 32'(out_data), 32'h14);

        // Test 5: drain after a single req[2] pulse. The pointer is now 5.
        req = 8'h04;
        #1;
        chk("drain_gnt", 32'(gnt), 32'h04);
        tick();
        req = 8'h00;
        chk("drain_valid1", 32'(out_valid), 32'h1);
        chk("drain_sel", 32'(out_sel), 32'h2);
        chk("drain_data", 32'(out_data), 32'h12);
        #1;
        chk("drain_nogrant", 32'(gnt), 32'h00);
        tick();
        chk("drain_valid0", 32'(out_valid), 32'h0);
        chk("drain_hold_sel", 32'(out_sel), 32'h2);
        tick();
        chk("drain_idle", 32'(out_valid), 32'h0);

        // Test 6: reset in the middle of a transfer. The pointer is now 3.
        req = 8'h80;
        #1;
        chk("mr_gnt7", 32'(gnt), 32'h80);
        tick();
        out_ready = 1'b0;
        req = 8'hFF;
        tick();
        chk("mr_stall_valid", 32'(out_valid), 32'h1);
        chk("mr_stall_sel", 32'(out_sel), 32'h7);
        rst = 1'b1;
        #1;
        chk("mr_valid0", 32'(out_valid), 32'h0);
        chk("mr_gnt0", 32'(gnt), 32'h00);
        chk("mr_sel0", 32'(out_sel), 32'h0);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("mr_first_gnt", 32'(gnt), 32'h01);
        tick();
        chk("mr_first_sel", 32'(out_sel), 32'h0);
        chk("mr_first_data", 32'(out_data), 32'h10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
